// File: rtl/fpnew_arb_pkg.sv
// Shared types and helpers for the opgroup slice arbiter and its ID FIFO.
package fpnew_arb_pkg;

  localparam int unsigned ARB_NUM_REQ     = 2;
  localparam int unsigned ARB_ID_W        = $clog2(ARB_NUM_REQ);
  localparam int unsigned ARB_REQ_W       = 128;
  localparam int unsigned ARB_RSP_W       = 40;
  localparam int unsigned ARB_MAX_OUTST   = 4;
  localparam int unsigned STALL_CNT_W     = 16;

  typedef logic [ARB_ID_W-1:0] req_id_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fpnew_arb_id_fifo.sv
// In-order requester-ID FIFO; pointers carry one extra wrap bit so full and empty differ.
module fpnew_arb_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [Width-1:0] mem_q [Depth];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i && !full_o) wr_d = wr_q + 1'b1;
      if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/fpnew_opgroup_slice_arbiter.sv
// Round-robin, grant-locking arbiter sharing one opgroup format slice between NumReq ports.
// Optional stall counter output enabled by FPNEW_ARB_STALL_CNT_EN.
module fpnew_opgroup_slice_arbiter import fpnew_arb_pkg::*; #(
  parameter int unsigned NumReq         = ARB_NUM_REQ,
  parameter int unsigned ReqWidth       = ARB_REQ_W,
  parameter int unsigned RspWidth       = ARB_RSP_W,
  parameter int unsigned MaxOutstanding = ARB_MAX_OUTST,
  parameter int unsigned IdWidth        = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][ReqWidth-1:0]  req_data_i,
  output logic                             slc_valid_o,
  input  logic                             slc_ready_i,
  output logic [ReqWidth-1:0]              slc_data_o,
  output logic                             slc_flush_o,
  input  logic                             slc_out_valid_i,
  output logic                             slc_out_ready_o,
  input  logic [RspWidth-1:0]              slc_rsp_i,
  output logic [NumReq-1:0]                rsp_valid_o,
  input  logic [NumReq-1:0]                rsp_ready_i,
  output logic [RspWidth-1:0]              rsp_data_o,
`ifdef FPNEW_ARB_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0]           stall_cnt_o,
`endif
  output logic                             busy_o
);

  logic [IdWidth-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, gnt, head;
  logic               lock_q, lock_d, any_req, full, empty, accept, pop, rsp_ok;
  int unsigned        idx;

  // A locked grant bypasses the search so the payload seen by the slice stays stable.
  always_comb begin
    gnt     = rr_q;
    any_req = 1'b0;
    idx     = 0;
    if (lock_q) begin
      gnt     = lock_idx_q;
      any_req = req_valid_i[lock_idx_q];
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        idx = (32'(rr_q) + i) % NumReq;
        if (!any_req && req_valid_i[IdWidth'(idx)]) begin
          any_req = 1'b1;
          gnt     = IdWidth'(idx);
        end
      end
    end
  end

  assign slc_valid_o = any_req && !full && !flush_i;
  assign accept      = slc_valid_o && slc_ready_i;
  assign req_ready_o = accept ? (NumReq'(1) << gnt) : '0;
  assign slc_data_o  = req_data_i[gnt];
  assign slc_flush_o = flush_i;

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      lock_d = 1'b0;
    end else if (accept) begin
      rr_d   = IdWidth'(rr_next(32'(gnt), NumReq));
      lock_d = 1'b0;
    end else if (slc_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  fpnew_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdWidth)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (accept),
    .data_i  (gnt),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // Responses arriving in the flush cycle belong to discarded operations.
  assign rsp_ok          = !empty && !flush_i;
  assign rsp_valid_o     = (slc_out_valid_i && rsp_ok) ? (NumReq'(1) << head) : '0;
  assign slc_out_ready_o = rsp_ready_i[head] && rsp_ok;
  assign pop             = slc_out_valid_i && slc_out_ready_o;
  assign rsp_data_o      = slc_rsp_i;
  assign busy_o          = !empty || lock_q;

`ifdef FPNEW_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (flush_i) stall_d = '0;
    else if (|req_valid_i && !accept && (stall_q != '1)) stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
